// File: rtl/snitch_icache_pkg.sv
// Instruction-cache shared types: L0/L1 event pulse bundles and the
// performance-counter index encoding used by the perf unit read port.
package snitch_icache_pkg;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
  } icache_l1_events_t;

  localparam int unsigned NumIcacheEvents = 9;

  typedef enum logic [3:0] {
    EvtL0Miss         = 4'd0,
    EvtL0Hit          = 4'd1,
    EvtL0Prefetch     = 4'd2,
    EvtL0DoubleHit    = 4'd3,
    EvtL0Stall        = 4'd4,
    EvtL1Miss         = 4'd5,
    EvtL1Hit          = 4'd6,
    EvtL1Stall        = 4'd7,
    EvtL1HandlerStall = 4'd8
  } icache_evt_e;

endpackage

// File: rtl/snitch_icache_perf_ctr.sv
// Single event counter: adds a small increment per enabled cycle, wraps or
// saturates, and keeps a sticky overflow flag.
module snitch_icache_perf_ctr #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned INC_WIDTH = 3,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  localparam int unsigned SumW = CNT_WIDTH + 1;

  // One extra bit holds the carry out, which is the overflow condition in both modes
  logic [SumW-1:0] sum;
  assign sum = {1'b0, cnt_o} + SumW'(inc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (enable_i) begin
      cnt_o <= (SATURATE && sum[CNT_WIDTH]) ? '1 : sum[CNT_WIDTH-1:0];
      ovf_o <= ovf_o | sum[CNT_WIDTH];
    end
  end

endmodule

// File: rtl/snitch_icache_perf_unit.sv
// I-cache performance unit: nine live event counters, a snapshot bank
// captured on snap_i, and a one-cycle-latency indexed snapshot read port.
module snitch_icache_perf_unit
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  icache_l1_events_t                      l1_events_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic                                   snap_i,
  input  logic [3:0]                             rd_idx_i,
  output logic [CNT_WIDTH-1:0]                   rd_data_o,
  output logic [NumIcacheEvents-1:0]             ovf_o
);

  localparam int unsigned IncW = $clog2(NR_FETCH_PORTS + 1);

  logic [NumIcacheEvents-1:0][IncW-1:0]      evt_inc;
  logic [NumIcacheEvents-1:0][CNT_WIDTH-1:0] cnt_q;
  logic [NumIcacheEvents-1:0][CNT_WIDTH-1:0] snap_q;
  logic [3:0]                                rd_idx_q;

  // L0 events arrive once per fetch port, so each counter adds the popcount
  always_comb begin
    evt_inc = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      evt_inc[EvtL0Miss]      += IncW'(l0_events_i[p].l0_miss);
      evt_inc[EvtL0Hit]       += IncW'(l0_events_i[p].l0_hit);
      evt_inc[EvtL0Prefetch]  += IncW'(l0_events_i[p].l0_prefetch);
      evt_inc[EvtL0DoubleHit] += IncW'(l0_events_i[p].l0_double_hit);
      evt_inc[EvtL0Stall]     += IncW'(l0_events_i[p].l0_stall);
    end
    evt_inc[EvtL1Miss]         = IncW'(l1_events_i.l1_miss);
    evt_inc[EvtL1Hit]          = IncW'(l1_events_i.l1_hit);
    evt_inc[EvtL1Stall]        = IncW'(l1_events_i.l1_stall);
    evt_inc[EvtL1HandlerStall] = IncW'(l1_events_i.l1_handler_stall);
  end

  for (genvar i = 0; i < NumIcacheEvents; i++) begin : g_ctr
    snitch_icache_perf_ctr #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (IncW),
      .SATURATE  (SATURATE)
    ) u_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .clear_i  (clear_i),
      .inc_i    (evt_inc[i]),
      .cnt_o    (cnt_q[i]),
      .ovf_o    (ovf_o[i])
    );
  end

  // Snapshot samples the live value before this edge's increment or clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q   <= '0;
      rd_idx_q <= '0;
    end else begin
      if (snap_i) snap_q <= cnt_q;
      rd_idx_q <= rd_idx_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NumIcacheEvents; i++) begin
      if (rd_idx_q == 4'(i)) rd_data_o = snap_q[i];
    end
  end

endmodule

// File: doc/snitch_icache_perf_unit.md
SNITCH_ICACHE_PERF_UNIT -- requirements
Module: snitch_icache_perf_unit

Interface
REQ-001 Parameter NR_FETCH_PORTS, default 4, number of L0 event vectors (>=1).
REQ-002 Parameter CNT_WIDTH, default 32, width of every counter (8..64).
REQ-003 Parameter SATURATE, default 1'b0: 1 = saturate at all-ones, 0 = wrap modulo 2^CNT_WIDTH.
REQ-004 clk_i  in  1  single clock; reset is synchronous and active-high.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 l0_events_i  in  NR_FETCH_PORTS x icache_l0_events_t  per-port L0 event pulses, one cycle each.
REQ-007 l1_events_i  in  icache_l1_events_t  L1 event pulses.
REQ-008 enable_i  in  1  counting enable.
REQ-009 clear_i  in  1  zero all live counters and overflow flags.
REQ-010 snap_i  in  1  copy all live counters into snapshot registers.
REQ-011 rd_idx_i  in  4  snapshot counter index (icache_evt_e encoding).
REQ-012 rd_data_o  out  CNT_WIDTH  snapshot value of registered index.
REQ-013 ovf_o  out  9  sticky per-counter overflow flags, live.

Function
REQ-014 SHALL keep 9 live counters: l0_miss, l0_hit, l0_prefetch, l0_double_hit, l0_stall, l1_miss, l1_hit, l1_stall, l1_handler_stall, indexed 0..8 in that order.
REQ-015 Each L0 counter SHALL add, per cycle with enable_i=1, the population count of its event bit across all NR_FETCH_PORTS (increment width clog2(NR_FETCH_PORTS+1), zero-extended).
REQ-016 Each L1 counter SHALL add 1 per cycle its event bit is high and enable_i=1.
REQ-017 With enable_i=0 live counters SHALL hold; events in that cycle are discarded.
REQ-018 Wrap mode: new value = (old + inc) mod 2^CNT_WIDTH; ovf flag set when the carry out is 1.
REQ-019 Saturate mode: new value = min(old + inc, 2^CNT_WIDTH-1); ovf flag set when the unclamped sum exceeds all-ones; counter then holds all-ones.
REQ-020 Ovf flags SHALL be sticky until clear_i or reset.
REQ-021 clear_i SHALL, next cycle, zero all live counters and ovf flags; clear wins over same-cycle events (those events lost).
REQ-022 snap_i SHALL, next cycle, load each snapshot register with the live value before that cycle's update (pre-increment, pre-clear).
REQ-023 snap_i and clear_i together: snapshot captures pre-clear values; live counters zeroed.
REQ-024 Read latency one cycle: rd_data_o in cycle n+1 = snapshot[rd_idx_i sampled at n], reflecting any snapshot written at edge n+1.
REQ-025 rd_idx_i > 8 SHALL yield rd_data_o = 0.
REQ-026 No state machine beyond counters; all outputs purely registered.

Reset
REQ-027 rst_i SHALL zero live counters, snapshot registers, ovf flags, registered read index and rd_data_o at the next clock edge.
REQ-028 Reset SHALL take priority over clear_i, snap_i and all events.
REQ-029 Reset asserted mid-accumulation SHALL discard that cycle's increments; counting resumes the cycle after rst_i deasserts.

Structure
REQ-030 snitch_icache_pkg SHALL gain enum icache_evt_e (9 values, order of REQ-014) and constant NumIcacheEvents = 9; existing event structs reused unchanged.
REQ-031 One sub-module snitch_icache_perf_ctr SHALL implement a single counter (inc input, enable, clear, SATURATE, ovf flag), instantiated 9 times.
REQ-032 Popcount per L0 event SHALL be combinational, in the top module.

Verification
REQ-033 NR_FETCH_PORTS=4, enable=1, l0_hit on all 4 ports for 10 cycles, snap -> read idx 1 returns 40; idx 0 returns 0.
REQ-034 CNT_WIDTH=8, SATURATE=0, preload 254 via 254 l1_miss pulses, then 3 more -> counter 1, ovf_o[5]=1.
REQ-035 CNT_WIDTH=8, SATURATE=1, same stimulus -> counter 255, ovf_o[5]=1; clear -> 0, ovf_o=0.
REQ-036 Counter at 7, l1_hit with clear_i and snap_i same cycle -> snapshot 7, live 0.
REQ-037 enable_i=0 for 5 cycles of l0_stall on 2 ports -> count unchanged; rd_idx_i=12 -> rd_data_o=0.
REQ-038 rst_i asserted for 1 cycle during continuous events -> all counters, snapshots, ovf_o and rd_data_o read 0 afterward; counting resumes next cycle.
